// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration helpers for the stopwatch control unit.
// State codes are visible on the debug port, so the encoding is fixed.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } sw_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of a counter that holds the values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, stable-level debounce and a
// one-cycle pulse on each accepted press (releases are filtered out).
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions both buttons, runs the IDLE/RUN/LAP/STOP FSM and
// produces the gated count tick, counter clear and display-hold controls.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_stop,
  input  logic               lap,
  output logic               cnt_tick,
  output logic               cnt_clr,
  output logic               disp_hold,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = cnt_width(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic          ss_p, lap_p;
  sw_state_e     state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          run_w;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ss_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (start_stop),
    .press_o (ss_p)
  );

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_lap_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (lap),
    .press_o (lap_p)
  );

  assign run_w = (state_q == ST_RUN) || (state_q == ST_LAP);

  // start/stop is checked first everywhere so it wins over a coincident lap press.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_p)       state_d = ST_STOP;
        else if (lap_p) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_p)       state_d = ST_STOP;
        else if (lap_p) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_p) begin
          state_d = ST_RUN;
        end else if (lap_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler freezes in STOP so a resume keeps the partial unit.
  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (run_w) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
    if (state_d == ST_IDLE) pre_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
    end
  end

  assign cnt_tick  = tick_q;
  assign cnt_clr   = clr_q;
  assign disp_hold = (state_q == ST_LAP);
  assign running   = run_w;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-cycle debounce window.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       ss;
  logic       lp;
  logic       cnt_tick;
  logic       cnt_clr;
  logic       disp_hold;
  logic       running;
  logic [1:0] state_w;

  stopwatch_ctrl #(
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (ss),
    .lap        (lp),
    .cnt_tick   (cnt_tick),
    .cnt_clr    (cnt_clr),
    .disp_hold  (disp_hold),
    .running    (running),
    .state      (state_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ss;
    logic       lp;
    logic [1:0] st;
    logic       tk;
    logic       cl;
    logic       hd;
    logic       rn;
  } vec_t;

  vec_t tbl [0:127];
  int   n_tbl;

  int n_checks;
  int n_errors;
  int tick_acc;
  int clr_acc;
  int dbl_cnt;
  int ovl_cnt;
  logic prev_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cnt_tick) tick_acc++;
    if (cnt_clr) clr_acc++;
    if (cnt_tick && prev_tick) dbl_cnt++;
    if (cnt_tick && cnt_clr) ovl_cnt++;
    prev_tick = cnt_tick;
  endtask

  task automatic add(input int n, input logic r, input logic s, input logic l,
                     input logic [1:0] st, input logic tk, input logic hd, input logic rn);
    for (int k = 0; k < n; k++) begin
      tbl[n_tbl] = '{rst: r, ss: s, lp: l, st: st, tk: tk, cl: 1'b0, hd: hd, rn: rn};
      n_tbl++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ss  = 1'b0;
    lp  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  int   chg_cnt;
  int   chg_idx;
  int   hold_cnt;
  int   clr_before;
  logic [1:0] prev_st;

  initial begin
    rst = 1'b1;
    ss = 1'b0;
    lp = 1'b0;
    n_checks = 0;
    n_errors = 0;
    tick_acc = 0;
    clr_acc = 0;
    dbl_cnt = 0;
    ovl_cnt = 0;
    prev_tick = 1'b0;
    n_tbl = 0;

    // Reset, idle, then a clean start press held down; ticks every 10 cycles.
    add(3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(50, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(6, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    add(10, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      add(1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
      add(9, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < n_tbl; i++) begin
      rst = tbl[i].rst;
      ss  = tbl[i].ss;
      lp  = tbl[i].lp;
      step();
      chk($sformatf("tbl[%0d].state", i), 32'(state_w), 32'(tbl[i].st));
      chk($sformatf("tbl[%0d].tick", i), 32'(cnt_tick), 32'(tbl[i].tk));
      chk($sformatf("tbl[%0d].clr", i), 32'(cnt_clr), 32'(tbl[i].cl));
      chk($sformatf("tbl[%0d].hold", i), 32'(disp_hold), 32'(tbl[i].hd));
      chk($sformatf("tbl[%0d].running", i), 32'(running), 32'(tbl[i].rn));
    end

    // Bounce: two 2-cycle glitches, then a held press; one transition 7 cycles after the last rise.
    do_reset();
    chg_cnt = 0;
    chg_idx = -1;
    prev_st = state_w;
    for (int i = 0; i < 28; i++) begin
      ss = (i < 8) ? ((i % 4) < 2) : 1'b1;
      step();
      if (state_w != prev_st) begin
        chg_cnt++;
        chg_idx = i;
      end
      prev_st = state_w;
    end
    chk("bounce_changes", 32'(chg_cnt), 32'd1);
    chk("bounce_change_idx", 32'(chg_idx), 32'd14);
    chk("bounce_state", 32'(state_w), 32'd1);
    ss = 1'b0;
    repeat (10) step();

    // Lap freeze and release.
    lp = 1'b1;
    repeat (7) step();
    chk("lap_state", 32'(state_w), 32'd2);
    chk("lap_hold", 32'(disp_hold), 32'd1);
    chk("lap_running", 32'(running), 32'd1);
    lp = 1'b0;
    tick_acc = 0;
    hold_cnt = 0;
    repeat (30) begin
      step();
      if (!disp_hold) hold_cnt++;
    end
    chk("lap_ticks_30cyc", 32'(tick_acc), 32'd3);
    chk("lap_hold_drops", 32'(hold_cnt), 32'd0);
    chk("lap_state_kept", 32'(state_w), 32'd2);
    lp = 1'b1;
    repeat (7) step();
    chk("unlap_state", 32'(state_w), 32'd1);
    chk("unlap_hold", 32'(disp_hold), 32'd0);
    lp = 1'b0;
    repeat (10) step();

    // Stop after 25 running cycles, resume keeps the partial unit, then clear.
    do_reset();
    ss = 1'b1;
    repeat (7) step();
    chk("sr_run", 32'(state_w), 32'd1);
    ss = 1'b0;
    tick_acc = 0;
    repeat (18) step();
    chk("sr_ticks_a", 32'(tick_acc), 32'd1);
    ss = 1'b1;
    tick_acc = 0;
    repeat (7) step();
    chk("sr_ticks_b", 32'(tick_acc), 32'd1);
    chk("sr_stop_state", 32'(state_w), 32'd3);
    chk("sr_stop_running", 32'(running), 32'd0);
    ss = 1'b0;
    tick_acc = 0;
    repeat (40) step();
    chk("sr_stop_ticks", 32'(tick_acc), 32'd0);
    chk("sr_stop_kept", 32'(state_w), 32'd3);
    ss = 1'b1;
    repeat (7) step();
    chk("sr_resume_state", 32'(state_w), 32'd1);
    ss = 1'b0;
    tick_acc = 0;
    repeat (4) step();
    chk("sr_resume_early", 32'(tick_acc), 32'd0);
    step();
    chk("sr_resume_tick5", 32'(cnt_tick), 32'd1);
    repeat (5) step();
    ss = 1'b1;
    repeat (7) step();
    chk("sr_stop2_state", 32'(state_w), 32'd3);
    ss = 1'b0;
    repeat (8) step();
    lp = 1'b1;
    repeat (6) step();
    chk("clr_before_edge", 32'(cnt_clr), 32'd0);
    chk("clr_state_before", 32'(state_w), 32'd3);
    step();
    chk("clr_state", 32'(state_w), 32'd0);
    chk("clr_pulse", 32'(cnt_clr), 32'd1);
    chk("clr_no_tick", 32'(cnt_tick), 32'd0);
    lp = 1'b0;
    step();
    chk("clr_width", 32'(cnt_clr), 32'd0);
    ss = 1'b1;
    repeat (7) step();
    chk("postclr_run", 32'(state_w), 32'd1);
    ss = 1'b0;
    tick_acc = 0;
    repeat (9) step();
    chk("postclr_early", 32'(tick_acc), 32'd0);
    step();
    chk("postclr_tick10", 32'(cnt_tick), 32'd1);

    // Coincident presses in RUN: start/stop wins.
    ss = 1'b1;
    lp = 1'b1;
    hold_cnt = 0;
    repeat (7) begin
      step();
      if (disp_hold) hold_cnt++;
    end
    chk("both_state", 32'(state_w), 32'd3);
    chk("both_hold_seen", 32'(hold_cnt), 32'd0);
    ss = 1'b0;
    lp = 1'b0;
    repeat (10) step();
    chk("both_state_kept", 32'(state_w), 32'd3);
    chk("both_hold", 32'(disp_hold), 32'd0);

    // Reset in the middle of LAP.
    ss = 1'b1;
    repeat (7) step();
    chk("mr_run", 32'(state_w), 32'd1);
    ss = 1'b0;
    repeat (8) step();
    lp = 1'b1;
    repeat (7) step();
    chk("mr_lap", 32'(state_w), 32'd2);
    chk("mr_lap_hold", 32'(disp_hold), 32'd1);
    lp = 1'b0;
    rst = 1'b1;
    clr_before = clr_acc;
    tick_acc = 0;
    step();
    chk("mr_state", 32'(state_w), 32'd0);
    chk("mr_tick", 32'(cnt_tick), 32'd0);
    chk("mr_clr", 32'(cnt_clr), 32'd0);
    chk("mr_hold", 32'(disp_hold), 32'd0);
    chk("mr_running", 32'(running), 32'd0);
    rst = 1'b0;
    repeat (20) step();
    chk("mr_idle_state", 32'(state_w), 32'd0);
    chk("mr_idle_ticks", 32'(tick_acc), 32'd0);
    chk("mr_no_clr", 32'(clr_acc), 32'(clr_before));

    chk("total_clr_pulses", 32'(clr_acc), 32'd1);
    chk("tick_wider_than_1", 32'(dbl_cnt), 32'd0);
    chk("tick_clr_overlap", 32'(ovl_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control unit for the stopwatch top level. It conditions the raw start/stop and lap push-buttons, runs the start/stop/lap/clear state machine, and generates the gated 1-cycle count tick that drives the time-of-day counter chain (h10..s1). It also controls display freeze for lap/split and clearing of the counters. The counter/7-segment datapath consumes its outputs directly.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, count tick rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, DIV >= 2
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles before a button level is accepted (>= 1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
start_stop  in  1  raw start/stop button, asynchronous, active-high
lap  in  1  raw lap/clear button, asynchronous, active-high
cnt_tick  out  1  one-cycle pulse, advance counter chain by one unit
cnt_clr  out  1  one-cycle pulse, zero counter chain
disp_hold  out  1  level, display latches shown value while high
running  out  1  level, high in RUN or LAP
state  out  2  current FSM state code, for debug and bench

Behaviour:
- Reset:
  - Only edge-sampled rst is honoured: synchronous, active-high.
  - While rst is high: state=IDLE, cnt_tick=0, cnt_clr=0, disp_hold=0, running=0.
  - Also cleared: prescaler=0, sync flops=0, debounce counters=0, debounced levels=0.
  - rst asserted mid-operation aborts everything on the next edge. No pulse is emitted in the reset cycle.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter resets whenever the synced level equals the debounced level. Otherwise it increments.
  - When it reaches DEBOUNCE_CYC-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - A press is a rising edge of the debounced level: a 1-cycle pulse (ss_p, lap_p). Releases produce no pulse.
  - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
  - Latency: a clean raw rising edge gives a press pulse 2+DEBOUNCE_CYC cycles later. State changes on the edge ending the pulse cycle.
- FSM state encoding: IDLE=00, RUN=01, LAP=10, STOP=11.
- FSM transitions:
  - IDLE: ss_p -> RUN. lap_p is ignored.
  - RUN: ss_p -> STOP; lap_p -> LAP.
  - LAP: lap_p -> RUN; ss_p -> STOP. Display is released, so the true stopped time is shown.
  - STOP: ss_p -> RUN (resume); lap_p -> IDLE with cnt_clr pulsed.
  - If ss_p and lap_p occur in the same cycle, ss_p wins and lap_p is discarded.
- Output and prescaler rules:
  - disp_hold = (state==LAP).
  - running = (state in {RUN,LAP}). Both are registered-state decodes with no extra latency beyond the state register.
  - Prescaler 0..DIV-1 increments only while running. It holds its value in STOP, so a resume keeps the fractional unit. It is cleared on entry to IDLE.
  - cnt_tick is registered: high for exactly one cycle following each cycle in which the prescaler is DIV-1 and running.
  - The first tick after IDLE->RUN appears DIV cycles after the cycle in which state first reads RUN.
- cnt_clr:
  - Registered, high exactly one cycle: the first cycle state reads IDLE after STOP.
  - Never coincident with cnt_tick.
- Ticks continue in LAP; only the display is frozen.
- A tick already registered when leaving RUN is still delivered; no tick is generated afterwards while in STOP.

Decomposition:
- Package stopwatch_pkg:
  - 2-bit state type and the four state codes.
  - Function computing DIV from CLK_HZ/TICK_HZ.
  - Function computing counter widths via clog2.
- Sub-module btn_conditioner (synchronizer, debounce, rise-pulse; parameter DEBOUNCE_CYC), instantiated twice.
- FSM and prescaler live in stopwatch_ctrl.

Test Plan:
(bench params: CLK_HZ=100, TICK_HZ=10 -> DIV=10, DEBOUNCE_CYC=4)
- Reset/idle: hold rst 3 cycles, then release. Outputs stay 0 for 50 cycles; state=00; no cnt_tick.
- Start and tick rate: clean press of start_stop.
  - state=01 exactly 7 cycles after the raw edge (2+4 to pulse, +1).
  - cnt_tick pulses at 10-cycle spacing, each 1 cycle wide.
  - 5 ticks in 50 cycles.
- Bounce rejection: start_stop toggled 1,0,1,0 with 2-cycle widths, then held high. Exactly one ss_p; one state change only.
- Lap freeze:
  - In RUN, press lap: disp_hold=1, state=10, ticks continue.
  - Press lap again: disp_hold=0, state=01.
  - Ticks between presses counted equal elapsed cycles/10.
- Stop/resume/clear:
  - Run 25 cycles then stop: prescaler holds 5, no ticks for 40 cycles.
  - Resume: first tick 5 cycles after state=01.
  - Stop, then lap: cnt_clr one cycle, state=00, prescaler=0.
- Simultaneous and reset mid-run:
  - Identical raw edges on both buttons in RUN: state=11 and disp_hold stays 0.
  - rst pulse during LAP: next cycle state=00, all outputs 0, no cnt_clr/cnt_tick emitted.
